inst_enc: RTL and testbench
===========================

// Module: inst_enc
// PURPOSE
//  RV32I instruction encoder; the inverse of the id stage. Accepts decoded field bundles
//  (opcode/rd/rs1/rs2/funct3/funct7/imm) over valid/ready and packs each into a 32-bit word.
//  Buffers the words, then writes them sequentially into the instruction ROM write port.
//  Used by the program loader and by self-checking benches that round-trip encode -> id.
// PARAMETERS
//  ADDR_W     12  ROM word-address width
//  BASE_ADDR  0   word address of the first write after start
//  FIFO_DEPTH 4   encoded-word buffer depth; must be a power of 2 and >= 2
// PORTS
//  clk        in   1       single clock
//  rst        in   1       asynchronous reset, active-high
//  start      in   1       pulse; rewinds address to BASE_ADDR and enters RUN
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       bundle accepted when in_valid && in_ready
//  in_opcode  in   7       opcode[6:0]
//  in_rd/in_rs1/in_rs2  in  5 each  register fields; for CSR-immediate forms, in_rs1 carries zimm
//  in_funct3  in   3       funct3
//  in_funct7  in   7       funct7; R-type and shift-immediate forms only
//  in_imm     in   32      byte-offset immediate; U-type uses imm[31:12]; CSR address in imm[11:0]
//  in_last    in   1       marks the final bundle of a program
//  rom_we     out  1       ROM write strobe
//  rom_addr   out  ADDR_W  ROM word address
//  rom_wdata  out  32      encoded instruction
//  rom_ready  in   1       ROM accepts the write when rom_we && rom_ready
//  done       out  1       high in DONE state
//  enc_err    out  1       one-cycle pulse on an encode error
//  err_cnt    out  8       encode-error count; saturates at 255; cleared by start
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO empty; rom_addr=BASE_ADDR; all outputs 0.
//  FSM IDLE -start-> RUN; RUN -(last accepted && FIFO empty && no write pending)-> DONE;
//   DONE -start-> RUN. start is ignored in RUN.
//  in_ready = (state==RUN) && !fifo_full && !last_seen. There is no pass-through when full.
//  Encoding is combinational from the in_* fields; the word is pushed into the FIFO on acceptance.
//  rom_we = !fifo_empty, so the first write appears 1 cycle after acceptance.
//  Pop when rom_we && rom_ready; rom_addr then increments by 1 and wraps modulo 2^ADDR_W.
//  A single cycle may contain both a push and a pop; occupancy is unchanged in that case.
//  Formats: LUI/AUIPC=U; JAL=J; JALR/LOAD/OP-IMM=I; STORE=S; BRANCH=B; OP=R.
//   OP-IMM with funct3 001/101: word = {funct7, imm[4:0], rs1, f3, rd, op}.
//  Encode errors (enc_err pulse, err_cnt+1; the truncated word is still written):
//   I/S imm outside signed 12-bit range; B imm outside signed 13-bit range or imm[0]!=0;
//   J imm outside signed 21-bit range or imm[0]!=0.
//  Unknown opcode: writes NOP 0x00000013 and raises an encode error.
//  Reset asserted mid-operation discards FIFO contents and any pending write immediately.
// CONFIGURATION
//  INST_ENC_CSR_EN defined: opcode 1110011 is encoded as {imm[11:0], rs1|zimm, f3, rd, op}.
//   funct3 000 or 100 is an unknown form and is handled like an unknown opcode.
//  INST_ENC_CSR_EN undefined: opcode 1110011 is handled like an unknown opcode.
// STRUCTURE
//  Opcode and funct3 constants come from define.v (INST_* macros shared with id).
//  Add to define.v: INST_NOP = 32'h0000_0013.
//  Sub-module inst_enc_fifo: synchronous FIFO, FIFO_DEPTH x 32, full/empty flags.
//  Top level holds the FSM, the combinational encoder, the address counter and the error counter.
// TESTING
//  addi x1,x0,5 (op 0010011,f3 0,imm 5) -> rom_wdata 0x00500093 @BASE_ADDR, 1 cycle after accept
//  lui x2,imm 0x12345000 -> 0x12345137; add x3,x1,x2 -> 0x002081B3
//  beq x1,x2,imm -4 -> 0xFE208EE3; sw x2,8(x1) -> 0x0020A423; jal x1,imm 8 -> 0x008000EF
//  opcode 0x7F -> 0x00000013 written, enc_err 1-cycle pulse, err_cnt=1; B imm=3 -> enc_err
//  rom_ready=0, 6 bundles offered -> in_ready drops after 4 accepts;
//   release rom_ready -> all 6 words written in order at consecutive addresses
//  ADDR_W=2, 5 words -> addresses 0,1,2,3,0; in_last on word 5 -> done=1 after the final write;
//   start -> done=0, rom_addr=0

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared opcode/funct3 constants, FSM state type and encoder result type for inst_enc.
// Encoding values match the RV32I base opcode map used by the decode stage.
package inst_enc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_CSR_RSV = 3'b100;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } enc_t;

  // True when v, read as two's complement, fits in an n-bit signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] s;
    s = 32'($signed(v) >>> (n - 1));
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_enc_if.sv
// Field-bundle input, ROM write port and status outputs of inst_enc.
// slave = encoder side, master = producer/ROM side.
interface inst_enc_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              rom_ready;
  logic              done;
  logic              enc_err;
  logic [7:0]        err_cnt;

  modport slave (
    input  start, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, in_last, rom_ready,
    output in_ready, rom_we, rom_addr, rom_wdata, done, enc_err, err_cnt
  );

  modport master (
    output start, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, in_last, rom_ready,
    input  in_ready, rom_we, rom_addr, rom_wdata, done, enc_err, err_cnt
  );
endinterface

// File: rtl/inst_enc_fifo.sv
// Synchronous DEPTH x W FIFO with full/empty flags; head word is visible combinationally.
// Push when full and pop when empty are ignored.
module inst_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wptr == r_rptr);
  // The extra pointer bit tells a full ring from an empty one.
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/inst_enc.sv
// RV32I encoder: packs field bundles into words, buffers them, writes them to ROM sequentially.
// Optional INST_ENC_CSR_EN enables SYSTEM/CSR encoding; otherwise opcode 1110011 is unknown.
module inst_enc
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  inst_enc_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last_seen;
  logic              r_done;
  logic              r_enc_err;
  logic [7:0]        r_err_cnt;

  logic [6:0]  w_op;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm;
  enc_t        w_enc;
  logic        w_accept;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;

  assign w_op  = bus.in_opcode;
  assign w_rd  = bus.in_rd;
  assign w_rs1 = bus.in_rs1;
  assign w_rs2 = bus.in_rs2;
  assign w_f3  = bus.in_funct3;
  assign w_f7  = bus.in_funct7;
  assign w_imm = bus.in_imm;

  // Unknown forms fall through to the default: NOP plus an error.
  always_comb begin
    w_enc.word = INST_NOP;
    w_enc.err  = 1'b1;
    case (w_op)
      OP_LUI, OP_AUIPC: begin
        w_enc.word = {w_imm[31:12], w_rd, w_op};
        w_enc.err  = 1'b0;
      end
      OP_JAL: begin
        w_enc.word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, w_op};
        w_enc.err  = !fits_signed(w_imm, 21) || w_imm[0];
      end
      OP_JALR, OP_LOAD: begin
        w_enc.word = {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
        w_enc.err  = !fits_signed(w_imm, 12);
      end
      OP_IMM: begin
        if (w_f3 == F3_SLL || w_f3 == F3_SRL)
          w_enc.word = {w_f7, w_imm[4:0], w_rs1, w_f3, w_rd, w_op};
        else
          w_enc.word = {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
        w_enc.err = !fits_signed(w_imm, 12);
      end
      OP_STORE: begin
        w_enc.word = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], w_op};
        w_enc.err  = !fits_signed(w_imm, 12);
      end
      OP_BRANCH: begin
        w_enc.word = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3, w_imm[4:1], w_imm[11], w_op};
        w_enc.err  = !fits_signed(w_imm, 13) || w_imm[0];
      end
      OP_OP: begin
        w_enc.word = {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_op};
        w_enc.err  = 1'b0;
      end
`ifdef INST_ENC_CSR_EN
      OP_SYSTEM: begin
        if (w_f3 != F3_PRIV && w_f3 != F3_CSR_RSV) begin
          w_enc.word = {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
          w_enc.err  = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.in_ready = (r_state == ST_RUN) && !w_full && !r_last_seen;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_pop        = !w_empty && bus.rom_ready;

  inst_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_accept),
    .i_data  (w_enc.word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.rom_we    = !w_empty;
  assign bus.rom_addr  = r_addr;
  assign bus.rom_wdata = w_empty ? 32'h0 : w_head;
  assign bus.done      = r_done;
  assign bus.enc_err   = r_enc_err;
  assign bus.err_cnt   = r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= LP_BASE;
      r_last_seen <= 1'b0;
      r_done      <= 1'b0;
      r_enc_err   <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_enc_err <= w_accept && w_enc.err;
      if (w_accept && w_enc.err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
      if (w_pop)
        r_addr <= r_addr + 1'b1;
      if (w_accept && bus.in_last)
        r_last_seen <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state     <= ST_RUN;
            r_addr      <= LP_BASE;
            r_last_seen <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_done      <= 1'b0;
          end
        end
        ST_RUN: begin
          // An empty FIFO means no write is outstanding either.
          if (r_last_seen && w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_enc.sv
// Randomized scoreboard bench for inst_enc with an arithmetic reference encoder.
module tb_inst_enc;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        last;
  } bnd_t;

  typedef struct {
    logic [31:0] w;
    logic [1:0]  a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  exp_t       exp_q[$];
  logic [1:0] am = 2'd0;
  int         em = 0;
  bit         rr_rand = 1'b0;
  bit         rr_fixed = 1'b1;
  int         acc_cnt = 0;

  inst_enc_if #(.ADDR_W(2)) bus();

  inst_enc #(
    .ADDR_W     (2),
    .BASE_ADDR  (0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference encoder: places each field at its bit offset with shifts and masks.
  function automatic void model(input bnd_t b, output logic [31:0] w, output bit e);
    logic [31:0] im, op, rd, rs1, rs2, f3, f7;
    int s;
    im = b.imm; op = 32'(b.op); rd = 32'(b.rd); rs1 = 32'(b.rs1);
    rs2 = 32'(b.rs2); f3 = 32'(b.f3); f7 = 32'(b.f7);
    s = int'($signed(b.imm));
    e = 1'b0;
    case (b.op)
      7'h37, 7'h17: w = (im & 32'hFFFF_F000) | (rd << 7) | op;
      7'h6F: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
          | (((im >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e = (s < -(1 << 20)) || (s >= (1 << 20)) || im[0];
      end
      7'h67, 7'h03, 7'h13: begin
        if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5))
          w = (f7 << 25) | ((im & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        else
          w = ((im & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      7'h23: begin
        w = (((im >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((im & 31) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | op;
        e = (s < -4096) || (s > 4095) || im[0];
      end
      7'h33: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
`ifdef INST_ENC_CSR_EN
      7'h73: begin
        if (b.f3 == 3'd0 || b.f3 == 3'd4) begin
          w = 32'h13; e = 1'b1;
        end else
          w = ((im & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
`endif
      default: begin w = 32'h13; e = 1'b1; end
    endcase
  endfunction

  function automatic bnd_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                              input logic last);
    bnd_t b;
    b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = 7'd0;
    b.imm = imm; b.last = last;
    return b;
  endfunction

  function automatic bnd_t rnd(input logic last);
    bnd_t b;
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0: b.op = 7'h37;  1: b.op = 7'h17;  2: b.op = 7'h6F;  3: b.op = 7'h67;
      4: b.op = 7'h03;  5: b.op = 7'h13;  6: b.op = 7'h23;  7: b.op = 7'h63;
      8: b.op = 7'h33;  9: b.op = 7'h73;  default: b.op = 7'($urandom);
    endcase
    b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3 = 3'($urandom); b.f7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: b.imm = $urandom;
      2: b.imm = (32'($urandom_range(0, 2097151)) - 32'h0010_0000) & ~32'h1;
      default: b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
    endcase
    b.last = last;
    return b;
  endfunction

  task automatic send(input bnd_t b, input logic [31:0] xw, input bit use_x);
    logic [31:0] w;
    bit e;
    exp_t x;
    int n;
    model(b, w, e);
    if (use_x) w = xw;
    @(negedge clk);
    bus.in_opcode = b.op; bus.in_rd = b.rd; bus.in_rs1 = b.rs1; bus.in_rs2 = b.rs2;
    bus.in_funct3 = b.f3; bus.in_funct7 = b.f7; bus.in_imm = b.imm; bus.in_last = b.last;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    x.w = w; x.a = am;
    exp_q.push_back(x);
    am = am + 2'd1;
    if (e && em < 255) em++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acc_cnt++;
    chk("enc_err", 32'(bus.enc_err), 32'(e));
    chk("err_cnt", 32'(bus.err_cnt), 32'(em));
  endtask

  task automatic pulse_start(input bit rewind);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (rewind) begin
      am = 2'd0;
      em = 0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("addr_at_done", 32'(bus.rom_addr), 32'(am));
    chk("ready_after_last", 32'(bus.in_ready), 32'd0);
  endtask

  // ROM-side backpressure, changed just after each active edge.
  initial begin
    bus.rom_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rom_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_fixed;
    end
  end

  // Monitor: every ROM write must match the oldest expected word and address.
  always @(negedge clk) begin
    if (!rst && bus.rom_we && bus.rom_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.rom_wdata, 32'hxxxx_xxxx);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("rom_wdata", bus.rom_wdata, x.w);
        chk("rom_addr", 32'(bus.rom_addr), 32'(x.a));
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
    bus.in_imm = '0; bus.in_last = 1'b0;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_rom_wdata", bus.rom_wdata, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_enc_err", 32'(bus.enc_err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Directed program with known encodings.
    pulse_start(1'b1);
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);
    send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0), 32'h0050_0093, 1'b1);
    chk("lat_rom_we", 32'(bus.rom_we), 32'd1);
    chk("lat_rom_wdata", bus.rom_wdata, 32'h0050_0093);
    chk("lat_rom_addr", 32'(bus.rom_addr), 32'd0);
    send(mk(7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b0), 32'h1234_5137, 1'b1);
    send(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0, 1'b0), 32'h0020_81B3, 1'b1);
    send(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC, 1'b0), 32'hFE20_8EE3, 1'b1);
    send(mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1'b0), 32'h0020_A423, 1'b1);
    send(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, 1'b0), 32'h0080_00EF, 1'b1);
    send(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b0), 32'h0000_0013, 1'b1);
    chk("err_cnt_unknown", 32'(bus.err_cnt), 32'd1);
    send(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0), 32'd0, 1'b0);
    chk("err_cnt_b_odd", 32'(bus.err_cnt), 32'd2);

    // Backpressure: four accepts fill the buffer, then release the ROM.
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    rr_fixed = 1'b0;
    repeat (3) @(negedge clk);
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rnd(i == 5), 32'd0, 1'b0);
      end
      begin
        repeat (12) @(negedge clk);
        chk("bp_accepts", 32'(acc_cnt), 32'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        rr_fixed = 1'b1;
      end
    join
    wait_done();

    // Restart from DONE, then a long random program with an ignored start mid-run.
    pulse_start(1'b1);
    chk("restart_done", 32'(bus.done), 32'd0);
    chk("restart_addr", 32'(bus.rom_addr), 32'd0);
    chk("restart_err_cnt", 32'(bus.err_cnt), 32'd0);
    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (i == 70) pulse_start(1'b0);
      send(rnd(i == 149), 32'd0, 1'b0);
    end
    wait_done();
    rr_rand = 1'b0;

    // Error counter saturation.
    pulse_start(1'b1);
    for (int i = 0; i < 260; i++)
      send(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, i == 259), 32'h0000_0013, 1'b1);
    wait_done();
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

    // Reset with words still buffered discards them at once.
    pulse_start(1'b1);
    rr_fixed = 1'b0;
    repeat (3) @(negedge clk);
    send(rnd(1'b0), 32'd0, 1'b0);
    send(rnd(1'b0), 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_addr", 32'(bus.rom_addr), 32'd0);
    chk("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rr_fixed = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
